// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan controller: time-slices NUM_DIGITS hex digits with
// brightness PWM, leading-zero blanking and a frame-synchronous load buffer.
module seg_scan_controller #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    sS_clk_i,
  input  logic                    sS_rst_i,
  input  logic                    sS_ld_valid_i,
  output logic                    sS_ld_ready_o,
  input  logic [4*NUM_DIGITS-1:0] sS_ld_data_i,
  input  logic [NUM_DIGITS-1:0]   sS_ld_dp_i,
  input  logic [NUM_DIGITS-1:0]   sS_ld_blank_i,
  input  logic                    sS_lzb_en_i,
  input  logic [3:0]              sS_bright_i,
  output logic [6:0]              sS_seg_o,
  output logic                    sS_dp_o,
  output logic [NUM_DIGITS-1:0]   sS_an_o,
  output logic                    sS_frame_o
);

  localparam int PW  = $clog2(REFRESH_DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRW = PW + 5;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic                    r_pend_full;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic [4*NUM_DIGITS-1:0] r_disp_data;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [NUM_DIGITS-1:0]   r_disp_blank;
  logic [3:0]              r_bright;
  logic                    r_lzb;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_frame;
  logic                    w_accept;
  logic [PRW-1:0]          w_prod;
  logic [PW:0]             w_duty;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_lz_dark;
  logic                    w_dark;
  logic                    w_on;
  logic [6:0]              w_glyph;

  assign w_frame       = (r_presc == PRESC_LAST) && (r_idx == IDX_LAST);
  assign w_accept      = sS_ld_valid_i && !r_pend_full;
  assign sS_ld_ready_o = !r_pend_full;
  assign sS_frame_o    = w_frame;
  assign sS_seg_o      = r_seg;
  assign sS_dp_o       = r_dp;
  assign sS_an_o       = r_an;

  always_ff @(posedge sS_clk_i or negedge sS_rst_i) begin
    if (!sS_rst_i) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Accept and frame copy never coincide: the copy needs pending_full, which holds ready low.
  always_ff @(posedge sS_clk_i or negedge sS_rst_i) begin
    if (!sS_rst_i) begin
      r_pend_full  <= 1'b0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '0;
      r_bright     <= 4'hF;
      r_lzb        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_data  <= sS_ld_data_i;
        r_pend_dp    <= sS_ld_dp_i;
        r_pend_blank <= sS_ld_blank_i;
        r_pend_full  <= 1'b1;
      end
      if (w_frame) begin
        r_bright <= sS_bright_i;
        r_lzb    <= sS_lzb_en_i;
        if (r_pend_full) begin
          r_disp_data  <= r_pend_data;
          r_disp_dp    <= r_pend_dp;
          r_disp_blank <= r_pend_blank;
          r_pend_full  <= 1'b0;
        end
      end
    end
  end

  assign w_prod = (PRW'(r_bright) + PRW'(1)) * PRW'(REFRESH_DIV);
  assign w_duty = w_prod[PRW-1:4];

  // A digit is a leading zero when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    logic w_all_zero;
    w_lz_dark  = '0;
    w_all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_all_zero = w_all_zero & (r_disp_data[4*k +: 4] == 4'h0);
      if (k != 0) w_lz_dark[k] = w_all_zero;
    end
  end

  always_comb begin
    w_nib  = r_disp_data[4*int'(r_idx) +: 4];
    w_dark = r_disp_blank[r_idx] | (r_lzb & w_lz_dark[r_idx]);
    w_on   = !w_dark && ({1'b0, r_presc} < w_duty);
  end

  always_comb begin
    case (w_nib)
      4'h0:    w_glyph = 7'b1111110;
      4'h1:    w_glyph = 7'b0110000;
      4'h2:    w_glyph = 7'b1101101;
      4'h3:    w_glyph = 7'b1111001;
      4'h4:    w_glyph = 7'b0110011;
      4'h5:    w_glyph = 7'b1011011;
      4'h6:    w_glyph = 7'b1011111;
      4'h7:    w_glyph = 7'b1110000;
      4'h8:    w_glyph = 7'b1111111;
      4'h9:    w_glyph = 7'b1111011;
      4'hA:    w_glyph = 7'b1110111;
      4'hB:    w_glyph = 7'b0011111;
      4'hC:    w_glyph = 7'b1001110;
      4'hD:    w_glyph = 7'b0111101;
      4'hE:    w_glyph = 7'b1001111;
      default: w_glyph = 7'b1000111;
    endcase
  end

  // Segments and dp are also dark during the PWM off-time to avoid ghosting.
  always_ff @(posedge sS_clk_i or negedge sS_rst_i) begin
    if (!sS_rst_i) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= SEG_ACTIVE_LOW;
    end else begin
      r_an  <= (w_on ? (AN_ONE << r_idx) : '0) ^ AN_OFF;
      r_seg <= (w_on ? w_glyph : 7'h00) ^ SEG_OFF;
      r_dp  <= (w_on & r_disp_dp[r_idx]) ^ SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clocks per digit slot, legal range 16..2^20.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1: 1 means a lit segment or decimal point drives 0.
REQ-004 Parameter AN_ACTIVE_LOW, default 0: 1 means the enabled anode drives 0.
REQ-005 sS_clk_i  in  1: the single clock; all logic is on its rising edge.
REQ-006 sS_rst_i  in  1: asynchronous, active-low reset.
REQ-007 sS_ld_valid_i  in  1: load request.
REQ-008 sS_ld_ready_o  out  1: load acceptance; a transfer occurs when valid and ready are both high.
REQ-009 sS_ld_data_i  in  4*NUM_DIGITS: hex nibbles; digit k is bits [4k+3:4k].
REQ-010 sS_ld_dp_i  in  NUM_DIGITS: decimal point per digit, 1 means lit.
REQ-011 sS_ld_blank_i  in  NUM_DIGITS: blank mask per digit, 1 means dark.
REQ-012 sS_lzb_en_i  in  1: leading-zero blanking enable, sampled at the frame boundary.
REQ-013 sS_bright_i  in  4: brightness code 0..15, sampled at the frame boundary.
REQ-014 sS_seg_o  out  7: segments {a,b,c,d,e,f,g} on bits [6:0], registered.
REQ-015 sS_dp_o  out  1: decimal point, registered.
REQ-016 sS_an_o  out  NUM_DIGITS: one-hot anode select, registered.
REQ-017 sS_frame_o  out  1: one-cycle pulse at each frame boundary.

Function
REQ-018 The prescaler counts 0..REFRESH_DIV-1 and wraps to 0; each wrap advances the digit index.
REQ-019 The digit index counts 0..NUM_DIGITS-1 and wraps to 0; NUM_DIGITS=1 holds the index at 0.
REQ-020 The frame boundary is the cycle where prescaler = REFRESH_DIV-1 and digit index = NUM_DIGITS-1; sS_frame_o is high on exactly that cycle.
REQ-021 The load path has a single pending buffer (data, dp, blank); sS_ld_ready_o = NOT pending_full.
REQ-022 On valid AND ready, the pending buffer captures all load inputs and pending_full is set on the next edge.
REQ-023 At a frame boundary with pending_full set, the pending buffer copies into the display registers and pending_full clears, so ready is high on the next cycle; the display never changes mid-frame.
REQ-024 A load accepted in the frame-boundary cycle fills the pending buffer and is displayed from the following boundary.
REQ-025 Brightness duty: duty = ((bright+1)*REFRESH_DIV) >> 4, computed at the boundary with enough width to avoid overflow.
REQ-026 The anode of the current digit is enabled only while prescaler < duty; otherwise all anodes are off, so bright=15 gives 100% on-time.
REQ-027 A digit is dark (no anode, segments off, dp off) if its blank bit is set.
REQ-028 With LZB enabled, a digit is also dark if it and every higher-indexed digit is 0 and it is not digit 0.
REQ-029 Glyphs are standard hex: 0-9, A, b, C, d, E, F; active-high '0' is 1111110, '1' is 0110000, '8' is 1111111.
REQ-030 The output polarity parameters invert seg/dp and an respectively after decode.
REQ-031 Outputs are registered one cycle after the index and prescaler state they reflect (latency 1).
REQ-032 Load inputs are ignored when ready is low; valid may drop without acceptance, with no side effects.

Reset
REQ-033 While sS_rst_i is low: prescaler, digit index, pending_full, display data, dp and blank are 0; the brightness code is 15; LZB is off.
REQ-034 While sS_rst_i is low: sS_an_o is all off, seg/dp are off (at polarity), sS_frame_o is 0 and sS_ld_ready_o is 1.
REQ-035 Reset asserted mid-frame or mid-load discards pending data immediately; after release, scanning restarts at digit 0 with prescaler 0.

Verification
REQ-036 NUM_DIGITS=4, REFRESH_DIV=16, bright=15: after reset, load data 16'h1234 -> after the first boundary, anodes cycle 0001,0010,0100,1000, each for 16 clocks; seg shows 4,3,2,1 respectively (active-low '1' = 1001111).
REQ-037 Load 16'hAAAA, then immediately 16'h5555 -> the second load stalls (ready low) until the boundary; the display stays AAAA for the whole frame and shows 5555 from the next frame.
REQ-038 bright=3 with REFRESH_DIV=16 -> the anode is on for 4 of 16 clocks per slot; bright=0 -> on for 1 clock.
REQ-039 LZB on, data 16'h0070, dp=0 -> digits 3 and 2 are dark and digits 1 and 0 show 7 and 0; data 16'h0000 -> only digit 0 is lit, showing 0.
REQ-040 Reset pulse asserted mid-slot with a load pending -> outputs go to the off state asynchronously; after release, ready=1, the display is blank-data 0, and no stale load appears.
